// File: rtl/uart_tx_buffer.sv
// Byte FIFO feeding a UART transmitter: queues bytes from the producer and
// issues one send pulse per byte, pacing on the transmitter's busy line.
module uart_tx_buffer #(
    parameter int DEPTH      = 16,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [7:0]            wr_data,
    input  logic                  wr_en,
    output logic                  full,
    output logic                  empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    input  logic                  clear_overflow,
    output logic [7:0]            tx_data,
    output logic                  tx_send,
    input  logic                  tx_busy
);

    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_SEND      = 2'd1;
    localparam logic [1:0] S_WAIT_ACK  = 2'd2;
    localparam logic [1:0] S_WAIT_DONE = 2'd3;

    localparam logic [ADDR_WIDTH:0] CNT_FULL = (ADDR_WIDTH + 1)'(DEPTH);

    logic [7:0]            mem_q [DEPTH];
    logic [1:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic                  overflow_q, overflow_d;
    logic [7:0]            tx_data_q, tx_data_d;
    logic                  wr_accept;
    logic                  pop;

    assign full     = (count_q == CNT_FULL);
    assign empty    = (count_q == '0);
    assign count    = count_q;
    assign overflow = overflow_q;
    assign tx_data  = tx_data_q;
    assign tx_send  = (state_q == S_SEND);

    assign wr_accept = wr_en && !full;
    assign pop       = (state_q == S_IDLE) && !empty && !tx_busy;

    always_comb begin
        state_d    = state_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        tx_data_d  = tx_data_q;

        if (wr_accept) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d  = rd_ptr_q + 1'b1;
            tx_data_d = mem_q[rd_ptr_q];
        end

        unique case ({wr_accept, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        // Clear beats a simultaneous dropped write.
        if (clear_overflow) begin
            overflow_d = 1'b0;
        end else if (wr_en && full) begin
            overflow_d = 1'b1;
        end

        unique case (state_q)
            S_IDLE:      if (pop) state_d = S_SEND;
            S_SEND:      state_d = S_WAIT_ACK;
            S_WAIT_ACK:  if (tx_busy) state_d = S_WAIT_DONE;
            S_WAIT_DONE: if (!tx_busy) state_d = S_IDLE;
            default:     state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            tx_data_q  <= 8'h00;
        end else begin
            state_q    <= state_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            tx_data_q  <= tx_data_d;
        end
    end

    // Storage needs no reset; stale entries are never read past count.
    always_ff @(posedge clock) begin
        if (wr_accept) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

endmodule

// File: doc/uart_tx_buffer.md
# uart_tx_buffer

Byte FIFO and send sequencer that sits directly upstream of the UART transmitter. User logic pushes bytes at any rate up to one per clock. The block stores them and hands them to the transmitter one at a time: it drives the transmitter's data and send inputs and watches its busy output. The result is back-to-back serial frames without the producer ever seeing the transmitter handshake.

## Interface
Parameters:
- DEPTH, 16: FIFO entries; power of two, ≥2.
- ADDR_WIDTH, 4: log2(DEPTH); must match DEPTH.

Ports:
- clock  input  1  system clock; all state changes on rising edge.
- reset  input  1  asynchronous, active-low reset. Low forces reset state immediately; release is synchronous to clock.
- wr_data  input  8  byte to enqueue.
- wr_en  input  1  enqueue strobe, one byte per cycle it is high.
- full  output  1  FIFO holds DEPTH bytes.
- empty  output  1  FIFO holds 0 bytes.
- count  output  ADDR_WIDTH+1  bytes currently stored, 0..DEPTH.
- overflow  output  1  sticky; set when a write is dropped.
- clear_overflow  input  1  clears overflow.
- tx_data  output  8  byte presented to transmitter data_in.
- tx_send  output  1  one-cycle send pulse to transmitter.
- tx_busy  input  1  transmitter busy line.

## Operation
- Storage: DEPTH x 8 array, rd_ptr and wr_ptr of ADDR_WIDTH bits each, and count register.
  - Pointers wrap naturally from DEPTH-1 to 0.
  - full = (count == DEPTH); empty = (count == 0). Both decode from the registered count.
- Write: on a clock edge with wr_en=1 and full=0, mem[wr_ptr] <= wr_data and wr_ptr increments.
- Dropped write: wr_en=1 with full=1 leaves the FIFO unchanged and sets overflow.
  - This holds even if a pop occurs in the same cycle, because full is sampled before the edge.
- Overflow priority: clear_overflow wins over a simultaneous set. The next dropped write sets overflow again.
- Pop: happens only on the IDLE->SEND transition.
  - tx_data <= mem[rd_ptr]; rd_ptr increments.
- Count update per edge:
  - +1 on write only.
  - -1 on pop only.
  - Unchanged on simultaneous accepted write and pop.
- Sequencer FSM, registered:
  - IDLE: if empty=0 and tx_busy=0, pop and go to SEND. Otherwise stay.
  - SEND: tx_send=1 for exactly this cycle. Unconditionally go to WAIT_ACK.
  - WAIT_ACK: stay until tx_busy=1, then go to WAIT_DONE.
  - WAIT_DONE: stay until tx_busy=0, then go to IDLE.
- tx_data holds the popped byte unchanged from SEND until the next pop. It never changes while the transmitter is loading or shifting.
- tx_send is a direct decode of state==SEND, so it is glitch-free and registered-state based. It is 0 in all other states.
- Busy already high in IDLE (transmitter busy from another cause): no pop occurs until it drops.
- Reset, including mid-frame:
  - state=IDLE; rd_ptr=wr_ptr=0; count=0.
  - tx_data=8'h00; tx_send=0; overflow=0.
  - Queued bytes are discarded; memory contents are don't-care.
- Reset values of outputs: full=0, empty=1, count=0, overflow=0, tx_data=8'h00, tx_send=0.

## Timing
- Write-to-visibility: count and empty update on the edge that accepts the write.
- Write-to-send latency from empty IDLE with tx_busy=0:
  - Byte written at edge N.
  - Pop and entry to SEND at edge N+1, so tx_send is high in cycle N+1..N+2.
  - WAIT_ACK from edge N+2.
- Round trip per byte: 1 IDLE cycle (minimum) + 1 SEND + WAIT_ACK duration + busy duration.
- Throughput limit: one byte per transmitter frame.
- WAIT_ACK has no timeout. The transmitter raises busy within a few cycles of send; a stuck-low busy stalls the sequencer by design.
- A busy pulse of a single cycle is sufficient to advance WAIT_ACK->WAIT_DONE->IDLE.
- Writes and overflow handling are independent of FSM state in every cycle.

## Test plan
- Reset, then a single write of 8'hA5 with a modelled transmitter (busy high 3 cycles after send, held 20 cycles) → empty falls then rises at the pop edge, tx_send high exactly 1 cycle, tx_data=8'hA5 throughout busy, state returns to IDLE.
- Burst of 5 consecutive writes 8'h01..8'h05 → five tx_send pulses, each only after busy from the previous byte has fallen, tx_data sequence 01,02,03,04,05, count peaks at 4 (one popped at first opportunity).
- Hold tx_busy=1, write DEPTH+2 bytes → full=1 after 16 writes, count=16, overflow=1, the last 2 bytes never transmitted; clear_overflow pulse → overflow=0; then release busy and verify the 16 stored bytes leave in order, including pointer wrap.
- With count=DEPTH, assert wr_en in the same cycle as the IDLE pop → write dropped, overflow=1, count=DEPTH-1 afterwards.
- Simultaneous write and pop with count=3 → count stays 3, and the new byte appears later in correct FIFO order.
- Assert reset low during WAIT_DONE with 4 bytes queued → immediately state=IDLE, count=0, empty=1, tx_send=0, tx_data=8'h00; after release, no send occurs until a new write.
